hack_ram_dp: RTL and testbench
==============================

Name: hack_ram_dp

Overview:
Parametrised successor to the Hack CPU data RAM. It has one read/write port (A), used by the CPU, and one independent read-only port (B), used by the display/debug path. It adds a hardware clear sequencer that zeroes the whole array after reset, a busy flag, selectable read latency, and selectable read-during-write semantics. It sits between the CPU datapath and the memory-mapped display logic, clocked by the CPU clock.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_LATENCY, 0, 0 = combinational read, 1 = registered read; applies to both ports
WRITE_FIRST, 0, RD_LATENCY=1 only; 0 = same-address read returns old data, 1 = returns new data
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = array contents untouched by reset

Ports:
CPUclk  input  1  CPU clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
busy  output  1  high while the clear sequence runs
a_addr  input  ADDR_W  port A address
a_we  input  1  port A write enable
a_wdata  input  DATA_W  port A write data
a_rdata  output  DATA_W  port A read data
b_addr  input  ADDR_W  port B address
b_rdata  output  DATA_W  port B read data

Behaviour:
- States: CLEAR, READY. Internal clear counter clr_cnt is ADDR_W bits wide.
- Reset sampled high at an edge:
  - CLEAR_ON_RESET=1: next state CLEAR, clr_cnt=0.
  - CLEAR_ON_RESET=0: next state READY.
  - In both cases the registered rdata outputs go to 0.
- CLEAR state:
  - Each cycle writes 0 to memory[clr_cnt] and increments clr_cnt.
  - On the cycle that clr_cnt==DEPTH-1, that word is written and the next state is READY.
  - Total duration is exactly DEPTH cycles after reset deasserts.
- busy:
  - busy=1 throughout CLEAR and during any cycle in which reset is held with CLEAR_ON_RESET=1.
  - busy=0 in READY.
  - After reset, busy is 1 if CLEAR_ON_RESET=1, otherwise 0.
- While busy:
  - a_we is ignored; CPU writes are dropped, not queued.
  - a_rdata and b_rdata read 0 regardless of address or latency mode.
- Reset asserted mid-CLEAR restarts the sequence at clr_cnt=0 with the full DEPTH-cycle duration.
- Port A write (READY only): memory[a_addr] <= a_wdata at the rising edge when a_we=1.
- RD_LATENCY=0:
  - a_rdata = memory[a_addr] and b_rdata = memory[b_addr], combinationally.
  - A write becomes visible on both ports in the cycle after the edge.
- RD_LATENCY=1:
  - Each rdata register loads the word at the address sampled at the edge; data is valid one cycle after the address is presented.
  - Read-during-write to the same address, on A or on B with b_addr==a_addr: WRITE_FIRST=0 returns the pre-write word; WRITE_FIRST=1 returns a_wdata.
- Out-of-range addresses (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W): writes are dropped and reads return 0.
- A and B may read the same or different addresses in the same cycle with no conflict and no stall.
- No X may propagate to outputs after the first reset.

Test Plan:
- Clear: CLEAR_ON_RESET=1, DEPTH=256. Hold reset 2 cycles, then release → busy high for exactly 256 cycles, then 0. Afterwards, reading addresses 0, 127 and 255 on both ports returns 0x0000.
- Blocked write: write 0xBEEF to addr 5 while busy=1 → after clear completes, addr 5 reads 0x0000.
- Basic R/W, RD_LATENCY=0:
  - Write 0x1234 to addr 0x10 and 0xFFFF to addr 0xFF.
  - Next cycle, a_rdata=0x1234 for a_addr=0x10, and b_rdata=0xFFFF for b_addr=0xFF in the same cycle.
- Read-during-write, RD_LATENCY=1: addr 3 holds 0x00AA; write 0x0055 to addr 3 with a_addr=b_addr=3 →
  - WRITE_FIRST=0: both rdata=0x00AA one cycle later and 0x0055 the cycle after.
  - WRITE_FIRST=1: both rdata=0x0055 one cycle later.
- Reset mid-clear: assert reset at clear cycle 100 for 1 cycle → busy remains high for a further 256 cycles after release. Then write 0x0001 to addr 0 and read it back as 0x0001.
- Non-power-of-2 depth: DEPTH=200, ADDR_W=8. Write 0x7777 to addr 210 → read of addr 210 returns 0, addr 199 is writable and readable, and the clear lasts 200 cycles.

Source files
------------

// File: rtl/hack_ram_dp.sv
// Dual-port data RAM for the Hack CPU: read/write port A and read-only port B, with
// a post-reset clear sequencer, a busy flag, selectable read latency and read-during-write mode.
module hack_ram_dp #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned RD_LATENCY     = 0,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              CPUclk,
    input  logic              reset,
    output logic              busy,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              a_in_range, b_in_range;
    logic              wr_en;
    logic [DATA_W-1:0] a_mem, b_mem;

    // State register
    always_ff @(posedge CPUclk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    // Outputs of the sequencer; busy also covers the reset cycles themselves
    always_comb begin
        busy  = (state_q == StClear) || (reset && (CLEAR_ON_RESET != 0));
        wr_en = a_we && !busy && !reset && a_in_range && (state_q == StReady);
    end

    always_comb begin
        a_in_range = {1'b0, a_addr} < DepthW;
        b_in_range = {1'b0, b_addr} < DepthW;
        a_mem      = a_in_range ? mem_q[a_addr] : '0;
        b_mem      = b_in_range ? mem_q[b_addr] : '0;
    end

    // Array has no reset of its own; only the clear sequencer zeroes it
    always_ff @(posedge CPUclk) begin
        if (state_q == StClear) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[a_addr] <= a_wdata;
        end
    end

    if (RD_LATENCY == 0) begin : g_comb_rd
        assign a_rdata = busy ? '0 : a_mem;
        assign b_rdata = busy ? '0 : b_mem;
    end else begin : g_reg_rd
        logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

        // Loading zero while busy keeps stale pre-clear data out of the first ready cycle
        always_ff @(posedge CPUclk) begin
            if (reset || busy) begin
                a_rdata_q <= '0;
                b_rdata_q <= '0;
            end else begin
                a_rdata_q <= ((WRITE_FIRST != 0) && wr_en) ? a_wdata : a_mem;
                b_rdata_q <= ((WRITE_FIRST != 0) && wr_en && (b_addr == a_addr)) ?
                             a_wdata : b_mem;
            end
        end

        assign a_rdata = busy ? '0 : a_rdata_q;
        assign b_rdata = busy ? '0 : b_rdata_q;
    end

endmodule

// File: tb/tb_hack_ram_dp.sv
// Scoreboard bench for hack_ram_dp: four instances (comb read, registered read-first,
// registered write-first, non-power-of-two depth) driven one at a time.
module tb_hack_ram_dp;

    localparam int SigBusy = 0;
    localparam int SigA    = 1;
    localparam int SigB    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst     [4];
    logic        busy_w  [4];
    logic [7:0]  a_addr  [4];
    logic [7:0]  b_addr  [4];
    logic        a_we    [4];
    logic [15:0] a_wdata [4];
    logic [15:0] a_rdata_w [4];
    logic [15:0] b_rdata_w [4];

    int depth_of [4] = '{256, 256, 256, 200};
    int lat_of   [4] = '{0, 1, 1, 0};

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        int          inst;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    hack_ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(0), .WRITE_FIRST(0),
                  .CLEAR_ON_RESET(1)) u_comb (
        .CPUclk(clk), .reset(rst[0]), .busy(busy_w[0]), .a_addr(a_addr[0]), .a_we(a_we[0]),
        .a_wdata(a_wdata[0]), .a_rdata(a_rdata_w[0]), .b_addr(b_addr[0]), .b_rdata(b_rdata_w[0])
    );

    hack_ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .WRITE_FIRST(0),
                  .CLEAR_ON_RESET(1)) u_rf (
        .CPUclk(clk), .reset(rst[1]), .busy(busy_w[1]), .a_addr(a_addr[1]), .a_we(a_we[1]),
        .a_wdata(a_wdata[1]), .a_rdata(a_rdata_w[1]), .b_addr(b_addr[1]), .b_rdata(b_rdata_w[1])
    );

    hack_ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .WRITE_FIRST(1),
                  .CLEAR_ON_RESET(1)) u_wf (
        .CPUclk(clk), .reset(rst[2]), .busy(busy_w[2]), .a_addr(a_addr[2]), .a_we(a_we[2]),
        .a_wdata(a_wdata[2]), .a_rdata(a_rdata_w[2]), .b_addr(b_addr[2]), .b_rdata(b_rdata_w[2])
    );

    hack_ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(0), .WRITE_FIRST(0),
                  .CLEAR_ON_RESET(1)) u_d200 (
        .CPUclk(clk), .reset(rst[3]), .busy(busy_w[3]), .a_addr(a_addr[3]), .a_we(a_we[3]),
        .a_wdata(a_wdata[3]), .a_rdata(a_rdata_w[3]), .b_addr(b_addr[3]), .b_rdata(b_rdata_w[3])
    );

    function automatic logic [15:0] pick(int k, int s);
        case (s)
            SigBusy: return {15'd0, busy_w[k]};
            SigA:    return a_rdata_w[k];
            default: return b_rdata_w[k];
        endcase
    endfunction

    // Monitor: compares every expectation that falls due on this cycle
    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                act = pick(sb[i].inst, sb[i].sig);
                checks++;
                if (sb[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s (inst %0d sig %0d): check missed its cycle %0d, now %0d",
                             sb[i].name, sb[i].inst, sb[i].sig, sb[i].due, cyc);
                end else if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (inst %0d sig %0d cyc %0d): got %h expected %h",
                             sb[i].name, sb[i].inst, sb[i].sig, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int k, int s, int d, logic [15:0] e, string n);
        exp_t x;
        x.due  = cyc + d;
        x.inst = k;
        x.sig  = s;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    // Assert reset for 'hold' edges, release it, and expect busy for exactly DEPTH cycles
    task automatic clear_seq(int k, int hold);
        rst[k] = 1'b1;
        push(k, SigBusy, 0, 16'd1, "busy_in_reset");
        repeat (hold) tick();
        rst[k] = 1'b0;
        for (int d = 0; d < depth_of[k]; d++) push(k, SigBusy, d, 16'd1, "busy_clear");
        push(k, SigBusy, depth_of[k], 16'd0, "busy_done");
    endtask

    task automatic wait_clear(int k);
        repeat (depth_of[k]) tick();
    endtask

    task automatic write(int k, logic [7:0] addr, logic [15:0] data);
        a_addr[k]  = addr;
        a_wdata[k] = data;
        a_we[k]    = 1'b1;
        tick();
        a_we[k]    = 1'b0;
    endtask

    task automatic read2(int k, logic [7:0] aa, logic [15:0] ea, logic [7:0] ba,
                         logic [15:0] eb, string n);
        a_addr[k] = aa;
        b_addr[k] = ba;
        push(k, SigA, lat_of[k], ea, n);
        push(k, SigB, lat_of[k], eb, n);
        tick();
    endtask

    // Read-during-write on address 3 with both ports looking at it
    task automatic rdw(int k, bit wf);
        a_addr[k]  = 8'd3;
        b_addr[k]  = 8'd3;
        a_wdata[k] = 16'h00AA;
        a_we[k]    = 1'b1;
        push(k, SigA, 1, wf ? 16'h00AA : 16'h0000, "rdw_first_write");
        push(k, SigB, 1, wf ? 16'h00AA : 16'h0000, "rdw_first_write");
        tick();
        a_wdata[k] = 16'h0055;
        push(k, SigA, 1, wf ? 16'h0055 : 16'h00AA, "rdw_same_edge");
        push(k, SigB, 1, wf ? 16'h0055 : 16'h00AA, "rdw_same_edge");
        tick();
        a_we[k] = 1'b0;
        push(k, SigA, 1, 16'h0055, "rdw_after");
        push(k, SigB, 1, 16'h0055, "rdw_after");
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k]     = 1'b1;
            a_addr[k]  = '0;
            b_addr[k]  = '0;
            a_we[k]    = 1'b0;
            a_wdata[k] = '0;
        end
        tick();

        // Combinational instance: clear, blocked write, basic R/W
        clear_seq(0, 2);
        a_addr[0]  = 8'd5;
        a_wdata[0] = 16'hBEEF;
        a_we[0]    = 1'b1;
        tick();
        a_we[0] = 1'b0;
        repeat (255) tick();
        read2(0, 8'd0, 16'h0000, 8'd127, 16'h0000, "clear_lo_mid");
        read2(0, 8'd255, 16'h0000, 8'd5, 16'h0000, "clear_hi_blocked");
        write(0, 8'h10, 16'h1234);
        write(0, 8'hFF, 16'hFFFF);
        read2(0, 8'h10, 16'h1234, 8'hFF, 16'hFFFF, "basic_rw");
        read2(0, 8'hFF, 16'hFFFF, 8'h10, 16'h1234, "basic_rw_swap");

        // Reset at clear cycle 100 restarts the full sequence
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (100) tick();
        push(0, SigBusy, 0, 16'd1, "busy_mid_clear");
        clear_seq(0, 1);
        wait_clear(0);
        write(0, 8'd0, 16'h0001);
        read2(0, 8'd0, 16'h0001, 8'h10, 16'h0000, "after_restart");

        // Registered read, read-first
        clear_seq(1, 1);
        wait_clear(1);
        read2(1, 8'd255, 16'h0000, 8'd0, 16'h0000, "rf_cleared");
        rdw(1, 1'b0);

        // Registered read, write-first
        clear_seq(2, 1);
        wait_clear(2);
        rdw(2, 1'b1);

        // Depth 200: out-of-range write dropped, last word usable
        clear_seq(3, 1);
        wait_clear(3);
        write(3, 8'd210, 16'h7777);
        read2(3, 8'd210, 16'h0000, 8'd10, 16'h0000, "oor_dropped");
        write(3, 8'd199, 16'hABCD);
        read2(3, 8'd199, 16'hABCD, 8'd199, 16'hABCD, "last_word");
        read2(3, 8'd210, 16'h0000, 8'd199, 16'hABCD, "oor_read_zero");

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
